encoder: RTL and testbench
==========================

// Module: encoder
// PURPOSE
//  Transmit side of the HSI serial link; mirrors the HSI decoder.
//  - Accepts one byte per valid/ready handshake.
//  - Serialises the byte as: start bit (0), 8 data bits, odd-parity bit, stop bit (1).
//  - Every bit lasts BIT_TICKS clk_en ticks.
//  - Drives the single-wire line that feeds a remote decoder.
// PARAMETERS
//  BIT_TICKS   8  clk_en ticks per bit (start, data and parity bits); must equal the decoder's bit period.
//  STOP_TICKS  8  clk_en ticks the stop bit is held; must be >= BIT_TICKS (decoder checks the stop bit at tick 86).
// PORTS
//  clk        in   1  single clock
//  rst        in   1  reset, synchronous, active-high
//  clk_en     in   1  tick enable; all state advances only on clk edges with clk_en=1
//  d          in   8  byte to send
//  d_vld      in   1  d valid
//  d_rdy      out  1  encoder can accept a byte
//  q          out  1  serial line, registered; idle level 1
//  busy       out  1  frame in progress
//  frame_end  out  1  one-clk pulse when the stop bit completes
//  pb_inj     in   1  parity error inject (present only with HSI_TX_PB_INJ_EN)
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, clk_en ignored)
//   - state=IDLE, q=1, d_rdy=1, busy=0, frame_end=0.
//   - Bit counter and tick counter cleared.
//  States
//   - IDLE:  q=1, d_rdy=1.
//     Accept when clk_en & d_vld & d_rdy: latch d into shift reg; parity=~^d; ->START; q<=0 at the same edge.
//   - START: hold q=0 for BIT_TICKS ticks -> DATA.
//   - DATA:  9 bits, BIT_TICKS each; ->STOP after the 9th bit.
//     LSB order (`ML_FST==`LSB): d[0]..d[7], then parity.
//     MSB order: d[7]..d[0], then parity.
//     Parity is always the last bit; order comes from hsi_config.vh.
//   - STOP:  q=1 for STOP_TICKS ticks; on the final tick: ->IDLE and frame_end=1 for that clk.
//  Timing
//   - Frame length = 10*BIT_TICKS + STOP_TICKS ticks (88 with defaults).
//   - Earliest next start bit = the first clk_en tick after frame_end (one IDLE tick minimum).
//  Handshake and gating
//   - d_rdy=0 and busy=1 in START/DATA/STOP.
//   - d and d_vld are ignored while busy; the latched byte is not affected.
//   - clk_en=0: all registers hold, q stable, frame_end=0.
//  Counters
//   - Tick counter: $clog2(STOP_TICKS)+1 bits; reloads at each bit boundary; no wrap inside a bit.
//   - Bit index: 4 bits, 0..8 in DATA.
//  Boundary conditions
//   - rst mid-frame: frame aborted; q=1 on the next edge; no frame_end.
//   - d_vld high on the same tick as the stop-bit end: not accepted (d_rdy=0); accepted on the next IDLE tick.
// CONFIGURATION
//  HSI_TX_PB_INJ_EN defined
//   - pb_inj port exists.
//   - pb_inj is sampled at accept; if 1, the transmitted parity bit is inverted for that frame only.
//  HSI_TX_PB_INJ_EN undefined
//   - No pb_inj port; parity is always ~^d.
// STRUCTURE
//  Shared (hsi_config.vh)
//   - `ML_FST, `LSB, START_BIT=0, STOP_BIT=1, state encodings.
//   - BIT_TICKS default shared with the decoder.
//  Sub-module en_bit_timer
//   - Tick counter with load/clk_en; outputs bit_done.
//   - Owned by the top-level FSM; the PISO shift register and FSM live in encoder.
// TESTING
//  1 Reset: rst=1 for 2 clk -> q=1, d_rdy=1, busy=0, frame_end=0.
//  2 LSB order, d=8'hA5, clk_en=1 -> q=0, then 1,0,1,0,0,1,0,1, parity 1, stop 1.
//    Each bit 8 clk; frame_end at clk 88; d_rdy=1 at clk 89.
//  3 MSB order, d=8'h01 -> q=0, then 0,0,0,0,0,0,0,1, parity 0, stop 1.
//  4 clk_en=1 every 4th clk, d=8'h3C -> frame spans 352 clk; q changes only on enabled edges.
//  5 rst at tick 40 of a frame -> q=1 and d_rdy=1 next clk; no frame_end; next byte sent cleanly.
//  6 Loopback into decoder: 256 bytes sent back-to-back.
//    -> every byte gives q_rdy with a matching q; pb_err=0 throughout.
//    With HSI_TX_PB_INJ_EN and pb_inj=1 on byte 5 -> decoder pb_err on byte 5 only.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared definitions for the HSI transmit path: states, line levels, bit order and frame packing.
package encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int DEF_BIT_TICKS  = 8;
    localparam int DEF_STOP_TICKS = 8;

    localparam logic LSB    = 1'b1;
    localparam logic MSB    = 1'b0;
    localparam logic ML_FST = LSB;

    // Packs the byte and parity into transmit order so the PISO always shifts out bit 0 first.
    function automatic logic [8:0] frame_bits(input logic [7:0] b, input logic order, input logic par);
        logic [7:0] rev;
        for (int i = 0; i < 8; i++) rev[i] = b[7-i];
        return (order == LSB) ? {par, b} : {par, rev};
    endfunction

endpackage

// File: rtl/encoder_bit_timer.sv
// Per-bit tick counter: reloads at each bit boundary and flags the last tick of the current bit.
module en_bit_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          bit_done
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clk_en) begin
            if (load)
                cnt <= load_val;
            else if (cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

    assign bit_done = clk_en && (cnt == CW'(1));

endmodule

// File: rtl/encoder.sv
// HSI serial transmitter: start bit, 8 data bits, odd parity, stop bit on a registered line.
// Optional parity-error injection port is enabled by defining HSI_TX_PB_INJ_EN.
module encoder
    import encoder_pkg::*;
#(
    parameter int   BIT_TICKS  = DEF_BIT_TICKS,
    parameter int   STOP_TICKS = DEF_STOP_TICKS,
    parameter logic BIT_ORDER  = ML_FST
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [7:0] d,
    input  logic       d_vld,
    output logic       d_rdy,
    output logic       q,
    output logic       busy,
    output logic       frame_end
`ifdef HSI_TX_PB_INJ_EN
    ,
    input  logic       pb_inj
`endif
);

    localparam int CW = $clog2(STOP_TICKS) + 1;

    state_t        state, next_state;
    logic          accept, load, bit_done, parity;
    logic [CW-1:0] load_val;
    logic [8:0]    shreg;
    logic [3:0]    bit_idx;

`ifdef HSI_TX_PB_INJ_EN
    assign parity = (~^d) ^ pb_inj;
`else
    assign parity = ~^d;
`endif

    assign d_rdy = (state == ST_IDLE);
    assign busy  = (state != ST_IDLE);

    en_bit_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .load     (load),
        .load_val (load_val),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load       = 1'b0;
        load_val   = CW'(BIT_TICKS);
        case (state)
            ST_IDLE: begin
                if (clk_en && d_vld) begin
                    accept     = 1'b1;
                    load       = 1'b1;
                    next_state = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    load       = 1'b1;
                    next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    load = 1'b1;
                    // Parity (index 8) just finished: the stop bit has its own length.
                    if (bit_idx == 4'd8) begin
                        load_val   = CW'(STOP_TICKS);
                        next_state = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            bit_idx   <= '0;
            q         <= STOP_BIT;
            frame_end <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            if (accept) begin
                shreg <= frame_bits(d, BIT_ORDER, parity);
                q     <= START_BIT;
            end else if (bit_done) begin
                case (state)
                    ST_START: begin
                        q       <= shreg[0];
                        shreg   <= {1'b0, shreg[8:1]};
                        bit_idx <= '0;
                    end
                    ST_DATA: begin
                        if (bit_idx == 4'd8) begin
                            q <= STOP_BIT;
                        end else begin
                            q       <= shreg[0];
                            shreg   <= {1'b0, shreg[8:1]};
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                    ST_STOP:  frame_end <= 1'b1;
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for encoder: LSB- and MSB-ordered instances share stimulus and are checked per clk.
module tb_encoder;
    import encoder_pkg::*;

    localparam int BT    = 8;
    localparam int ST    = 8;
    localparam int FRAME = 10 * BT + ST;

    logic       clk = 1'b0;
    logic       rst, clk_en, d_vld;
    logic [7:0] d;
    logic       d_rdy_l, q_l, busy_l, fe_l;
    logic       d_rdy_m, q_m, busy_m, fe_m;
`ifdef HSI_TX_PB_INJ_EN
    logic       pb_inj;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    encoder #(.BIT_TICKS(BT), .STOP_TICKS(ST), .BIT_ORDER(LSB)) dut_lsb (
        .clk(clk), .rst(rst), .clk_en(clk_en), .d(d), .d_vld(d_vld),
        .d_rdy(d_rdy_l), .q(q_l), .busy(busy_l), .frame_end(fe_l)
`ifdef HSI_TX_PB_INJ_EN
        , .pb_inj(pb_inj)
`endif
    );

    encoder #(.BIT_TICKS(BT), .STOP_TICKS(ST), .BIT_ORDER(MSB)) dut_msb (
        .clk(clk), .rst(rst), .clk_en(clk_en), .d(d), .d_vld(d_vld),
        .d_rdy(d_rdy_m), .q(q_m), .busy(busy_m), .frame_end(fe_m)
`ifdef HSI_TX_PB_INJ_EN
        , .pb_inj(pb_inj)
`endif
    );

    // Line level expected k enabled ticks after the accept edge, straight from the frame layout.
    function automatic logic exp_line(input logic [7:0] b, input bit lsb, input bit inj, input int k);
        int slot;
        slot = k / BT;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return lsb ? b[slot-1] : b[8-slot];
        if (slot == 9) return ((^b) ? 1'b0 : 1'b1) ^ inj;
        return 1'b1;
    endfunction

    task automatic step(input logic en);
        clk_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic set_inj(input bit v);
`ifdef HSI_TX_PB_INJ_EN
        pb_inj = v;
`else
        if (v) $display("[TB] parity injection requested but not built in");
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; d_vld = 1'b0; d = 8'h00; set_inj(1'b0);
        step(1'b0);
        step(1'b1);
        n_cmp++;
        if ({q_l, d_rdy_l, busy_l, fe_l} !== 4'b1100) begin
            n_err++;
            $display("[TB] FAIL reset_lsb: q/rdy/busy/fe=%b required 1100", {q_l, d_rdy_l, busy_l, fe_l});
        end
        n_cmp++;
        if ({q_m, d_rdy_m, busy_m, fe_m} !== 4'b1100) begin
            n_err++;
            $display("[TB] FAIL reset_msb: q/rdy/busy/fe=%b required 1100", {q_m, d_rdy_m, busy_m, fe_m});
        end
        rst = 1'b0;
    endtask

    // Sends one byte with clk_en every `period` clks; next_b is presented during the stop bit.
    task automatic run_frame(input logic [7:0] b, input int period, input bit inj, input logic [7:0] next_b);
        int  k = -1;
        int  c = 0;
        bit  en;
        d = b; d_vld = 1'b1; set_inj(inj);
        while (k < FRAME && c < period * (FRAME + 4)) begin
            en = (c % period) == 0;
            step(en);
            c++;
            if (en) k++;
            if (k < FRAME) begin
                n_cmp++;
                if (q_l !== exp_line(b, 1'b1, inj, k) || q_m !== exp_line(b, 1'b0, inj, k)) begin
                    n_err++;
                    $display("[TB] FAIL line byte=%h tick=%0d: q_lsb=%b q_msb=%b required %b/%b", b, k,
                             q_l, q_m, exp_line(b, 1'b1, inj, k), exp_line(b, 1'b0, inj, k));
                end
                n_cmp++;
                if ({busy_l, d_rdy_l, fe_l, busy_m, d_rdy_m, fe_m} !== 6'b100100) begin
                    n_err++;
                    $display("[TB] FAIL busy byte=%h tick=%0d: busy/rdy/fe=%b required 100100", b, k,
                             {busy_l, d_rdy_l, fe_l, busy_m, d_rdy_m, fe_m});
                end
                if (k >= FRAME - ST) begin
                    d = next_b; d_vld = 1'b1;
                end else begin
                    d = 8'($urandom); d_vld = 1'($urandom); set_inj(1'($urandom));
                end
            end else begin
                n_cmp++;
                if ({q_l, busy_l, d_rdy_l, fe_l, q_m, busy_m, d_rdy_m, fe_m} !== 8'b1011_1011) begin
                    n_err++;
                    $display("[TB] FAIL frame_end byte=%h: q/busy/rdy/fe=%b required 10111011", b,
                             {q_l, busy_l, d_rdy_l, fe_l, q_m, busy_m, d_rdy_m, fe_m});
                end
            end
        end
        if (k < FRAME) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL timeout byte=%h: reached tick %0d required %0d", b, k, FRAME);
        end
        if (period > 1) begin
            step(1'b0);
            n_cmp++;
            if ({q_l, d_rdy_l, fe_l, q_m, d_rdy_m, fe_m} !== 6'b110110) begin
                n_err++;
                $display("[TB] FAIL after_end byte=%h: q/rdy/fe=%b required 110110", b,
                         {q_l, d_rdy_l, fe_l, q_m, d_rdy_m, fe_m});
            end
        end
    endtask

    task automatic test_orders();
        run_frame(8'hA5, 1, 1'b0, 8'h01);
        run_frame(8'h01, 1, 1'b0, 8'h3C);
    endtask

    task automatic test_clk_en_gating();
        run_frame(8'h3C, 4, 1'b0, 8'hC3);
        run_frame(8'hC3, 3, 1'b0, 8'h5A);
    endtask

    task automatic test_abort();
        d = 8'h5A; d_vld = 1'b1; set_inj(1'b0);
        step(1'b1);
        d_vld = 1'b0;
        for (int i = 0; i < 40; i++) step(1'b1);
        rst = 1'b1;
        step(1'($urandom));
        rst = 1'b0;
        n_cmp++;
        if ({q_l, d_rdy_l, busy_l, fe_l, q_m, d_rdy_m, busy_m, fe_m} !== 8'b1100_1100) begin
            n_err++;
            $display("[TB] FAIL abort: q/rdy/busy/fe=%b required 11001100",
                     {q_l, d_rdy_l, busy_l, fe_l, q_m, d_rdy_m, busy_m, fe_m});
        end
        for (int i = 0; i < 60; i++) begin
            step(1'b1);
            n_cmp++;
            if ({q_l, fe_l, q_m, fe_m} !== 4'b1010) begin
                n_err++;
                $display("[TB] FAIL abort_idle clk=%0d: q/fe=%b required 1010", i, {q_l, fe_l, q_m, fe_m});
            end
        end
        run_frame(8'h96, 1, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [0:256];
        bit         inj;
        for (int i = 0; i <= 256; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            inj = 1'b0;
`ifdef HSI_TX_PB_INJ_EN
            inj = (i == 5);
`endif
            run_frame(bytes[i], 1, inj, bytes[i+1]);
        end
        d_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_orders();
        test_clk_en_gating();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
